// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between an issuing pipeline and
// the muldiv_seq multi-cycle ALU sequencer.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. A response transfers on a rising edge where
// resp_valid and resp_ready are both 1. Until then, resp_data, resp_tag
// and dz_flag are held stable.
interface muldiv_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        dz_flag;

  // Issuing side.
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, dz_flag
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, dz_flag
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: holds operands on a shared combinational ALU for the number
// of cycles its slow paths need, then presents the result as a response.
//
// ALU op encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7 SRA=8
// MUL=9 DIV=10 MOD=11; codes 12..15 are undefined and sequenced with
// single-cycle latency.
//
// Optional feature macro: MULDIV_DIVZERO_BYPASS_EN. When defined, DIV/MOD
// by zero skip the ALU and answer the cycle after accept with all-ones
// (DIV) or the dividend (MOD), flagged by dz_flag. When undefined, divide
// by zero runs the full divide latency and dz_flag is tied low.
module muldiv_seq #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  muldiv_seq_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_y,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] ALU_MUL = 4'd9;
  localparam logic [3:0] ALU_DIV = 4'd10;
  localparam logic [3:0] ALU_MOD = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [3:0]  lat_m1;
  logic        accept;
  logic        capture;
  logic        skip_exec;
  logic [31:0] resp_data_q;
  logic [4:0]  tag_q;

`ifdef MULDIV_DIVZERO_BYPASS_EN
  logic        dz_q;
  logic [31:0] dz_result;

  assign skip_exec = ((bus.req_op == ALU_DIV) || (bus.req_op == ALU_MOD)) &&
                     (bus.req_b == 32'd0);
  assign dz_result = (bus.req_op == ALU_DIV) ? 32'hFFFF_FFFF : bus.req_a;
  assign bus.dz_flag = dz_q;
`else
  assign skip_exec   = 1'b0;
  assign bus.dz_flag = 1'b0;
`endif

  // A new request is taken when idle, or in DONE while the current
  // response is being consumed; flush and reset block acceptance.
  assign bus.req_ready = ~rst & ~flush &
                         ((state_q == IDLE) ||
                          ((state_q == DONE) && bus.resp_ready));
  assign accept        = bus.req_valid & bus.req_ready;

  assign bus.resp_valid = (state_q == DONE) & ~flush;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = tag_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;

  // Cycles-minus-one the ALU needs for the incoming op.
  always_comb begin
    lat_m1 = 4'd0;
    case (bus.req_op)
      ALU_MUL:          lat_m1 = 4'(MUL_LAT - 1);
      ALU_DIV, ALU_MOD: lat_m1 = 4'(DIV_LAT - 1);
      default:          lat_m1 = 4'd0;
    endcase
  end

  // Next-state, down-counter and result-capture decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (accept) begin
      state_d = skip_exec ? DONE : EXEC;
      cnt_d   = skip_exec ? 4'd0 : lat_m1;
    end else begin
      case (state_q)
        EXEC: begin
          if (cnt_q == 4'd0) begin
            state_d = DONE;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (bus.resp_ready) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand, tag and result registers; ALU inputs only move on an accept
  // that enters EXEC, so they hold their last values everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_op      <= 4'd0;
      tag_q       <= 5'd0;
      resp_data_q <= 32'd0;
`ifdef MULDIV_DIVZERO_BYPASS_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      if (accept && !skip_exec) begin
        alu_a  <= bus.req_a;
        alu_b  <= bus.req_b;
        alu_op <= bus.req_op;
      end
      if (accept) tag_q <= bus.req_tag;
      if (capture) resp_data_q <= alu_y;
`ifdef MULDIV_DIVZERO_BYPASS_EN
      if (accept) dz_q <= skip_exec;
      if (accept && skip_exec) resp_data_q <= dz_result;
`endif
    end
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, cycles the ALU multiply path needs to settle (range 1..15).
REQ-002 SHALL have parameter DIV_LAT, default 8, cycles the ALU divide/mod path needs to settle (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_op  input  4  ALU op code per decode.vh ALU_* defines.
REQ-008 SHALL have ports req_a, req_b  input  32 each  operands.
REQ-009 SHALL have port req_tag  input  5  destination register tag, returned unchanged.
REQ-010 SHALL have port flush  input  1  synchronous abort of any in-flight op.
REQ-011 SHALL have ports alu_a, alu_b  output  32 each, and alu_op  output  4, driving the shared ALU.
REQ-012 SHALL have port alu_y  input  32  ALU result.
REQ-013 SHALL have ports resp_valid  output  1, resp_ready  input  1, resp_data  output  32, resp_tag  output  5.
REQ-014 SHALL have port busy  output  1, high whenever state is not IDLE.
REQ-015 SHALL have port dz_flag  output  1  response came from a divide-by-zero.

Function
REQ-016 SHALL implement states IDLE, EXEC, DONE.
REQ-017 req_ready SHALL be 1 in IDLE, 1 in DONE only while resp_ready is 1, else 0.
REQ-018 Accept (req_valid & req_ready) SHALL register req_a, req_b, req_op, req_tag and enter EXEC next cycle.
REQ-019 Latency L SHALL be MUL_LAT for ALU_MUL, DIV_LAT for ALU_DIV/ALU_MOD, 1 for any other op.
REQ-020 In EXEC, alu_a/alu_b/alu_op SHALL be driven from the registered operands, stable for all L cycles; outside EXEC they SHALL hold their last values.
REQ-021 EXEC SHALL last exactly L cycles (down-counter loaded with L-1 at accept); on the last EXEC cycle alu_y SHALL be captured into resp_data and state SHALL move to DONE.
REQ-022 In DONE, resp_valid SHALL be 1 and resp_data/resp_tag/dz_flag SHALL be stable until resp_ready is 1.
REQ-023 DONE with resp_ready=1: new accept SHALL go to EXEC, otherwise IDLE; no bubble on back-to-back.
REQ-024 Accept-to-resp_valid SHALL be L+1 cycles.
REQ-025 flush SHALL have top priority: next state IDLE, resp_valid 0, no accept in the flush cycle even if req_valid=1.
REQ-026 Op codes outside ALU_* definitions SHALL still be sequenced with L=1; result is whatever the ALU returns (0 for default).

Reset
REQ-027 rst asserted SHALL immediately force IDLE, counter 0, resp_valid 0, resp_data 0, resp_tag 0, dz_flag 0, alu_a/alu_b 0, alu_op 0, busy 0; req_ready SHALL be 1 after release.
REQ-028 rst mid-EXEC or mid-DONE SHALL discard the operation with no response.

Configuration
REQ-029 Macro MULDIV_DIVZERO_BYPASS_EN defined: ALU_DIV/ALU_MOD with req_b==0 SHALL skip EXEC, reach DONE the cycle after accept with resp_data 32'hFFFF_FFFF (DIV) or req_a (MOD) and dz_flag 1.
REQ-030 Macro MULDIV_DIVZERO_BYPASS_EN undefined: divide-by-zero SHALL take DIV_LAT cycles, return alu_y, and dz_flag SHALL be tied to 0.

Verification
REQ-031 MUL a=7, b=-3, resp_ready=1 -> resp_valid at cycle 3 after accept, resp_data 32'hFFFF_FFEB, tag echoed.
REQ-032 DIV a=100, b=7, then MOD a=100, b=7 back-to-back -> 14 at cycle 9, 2 at cycle 18, req_ready high in each DONE cycle.
REQ-033 DIV a=5, b=0 -> with macro: 32'hFFFF_FFFF after 1 cycle, dz_flag 1; without: response after 9 cycles, dz_flag 0.
REQ-034 MUL accepted, resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable, req_ready 0 throughout.
REQ-035 flush asserted on 4th EXEC cycle of DIV with req_valid=1 -> IDLE next cycle, no response, no accept.
REQ-036 rst pulsed asynchronously mid-EXEC -> all outputs 0 immediately, busy 0, next ADD a=1, b=2 returns 3 after 2 cycles.
